// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - core, loader and lane-bus signals for dmem_ctrl
//
// Core port:   c_req/c_ready request handshake, c_we, c_size, c_unsigned,
//              c_addr, c_wdata; response c_rvalid, c_rdata, c_err.
// Loader port: l_req/l_ready request handshake, l_addr, l_wdata;
//              response l_ack, l_err.
// Lane bus:    mem_addr, mem_we, mem_wdata to the four byte lanes;
//              mem_rdata back from them.
// slave is the controller's view, master the requester/memory side.
interface dmem_ctrl_if;
  logic        c_req;
  logic        c_ready;
  logic        c_we;
  logic [1:0]  c_size;
  logic        c_unsigned;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        c_err;
  logic        l_req;
  logic        l_ready;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_ack;
  logic        l_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    input  l_req, l_addr, l_wdata, mem_rdata,
    output c_ready, c_rvalid, c_rdata, c_err,
    output l_ready, l_ack, l_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    output l_req, l_addr, l_wdata, mem_rdata,
    input  c_ready, c_rvalid, c_rdata, c_err,
    input  l_ready, l_ack, l_err,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - four-lane data memory sequencer with core/loader arbitration
//
// Ports: clk (rising edge), rst_n (asynchronous active-low reset),
//        bus (dmem_ctrl_if.slave): core and loader request/response
//        handshakes plus the shared byte-lane memory bus.
// One access per IDLE -> ACCESS -> RESP pass; the lane bus is only
// driven while in ACCESS.
module dmem_ctrl #(
  parameter int MEM_WORDS = 151
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic        rr_q;       // 1: loader wins the next tie
  logic        own_q;      // 1: loader owns the current access
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  alo_q;
  logic        c_rvalid_q;
  logic        c_err_q;
  logic [31:0] c_rdata_q;
  logic        l_ack_q;
  logic        l_err_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_we_q;
  logic [31:0] mem_wdata_q;

  logic        grant_c;
  logic        grant_l;
  logic        g_we;
  logic        g_uns;
  logic        g_err;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  mem_we_d;
  logic [31:0] mem_wdata_d;
  logic [31:0] ld_data_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign grant_c = (state_q == IDLE) && bus.c_req && (!bus.l_req || !rr_q);
  assign grant_l = (state_q == IDLE) && bus.l_req && !grant_c;

  assign bus.c_ready   = grant_c;
  assign bus.l_ready   = grant_l;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.c_err     = c_err_q;
  assign bus.l_ack     = l_ack_q;
  assign bus.l_err     = l_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Loader traffic is always a word store.
  always_comb begin
    g_we    = bus.c_we;
    g_size  = bus.c_size;
    g_uns   = bus.c_unsigned;
    g_addr  = bus.c_addr;
    g_wdata = bus.c_wdata;
    if (grant_l) begin
      g_we    = 1'b1;
      g_size  = 2'b10;
      g_uns   = 1'b0;
      g_addr  = bus.l_addr;
      g_wdata = bus.l_wdata;
    end
  end

  always_comb begin
    g_err = ({2'b00, g_addr[31:2]} >= 32'(MEM_WORDS));
    case (g_size)
      2'b01:   g_err = g_err | g_addr[0];
      2'b10:   g_err = g_err | (|g_addr[1:0]);
      2'b11:   g_err = 1'b1;
      default: g_err = g_err;
    endcase
  end

  // Store lane enables and replicated data, computed at grant so the lane
  // bus is registered and valid for the whole ACCESS cycle.
  always_comb begin
    mem_we_d    = 4'b0000;
    mem_wdata_d = 32'h0;
    if (g_we && !g_err) begin
      case (g_size)
        2'b00: begin
          mem_we_d    = 4'b0001 << g_addr[1:0];
          mem_wdata_d = {4{g_wdata[7:0]}};
        end
        2'b01: begin
          mem_we_d    = g_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata_d = {2{g_wdata[15:0]}};
        end
        default: begin
          mem_we_d    = 4'b1111;
          mem_wdata_d = g_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{alo_q, 3'b000} +: 8];
    ld_half = alo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data_d = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_data_d = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_data_d = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      alo_q       <= 2'b00;
      c_rvalid_q  <= 1'b0;
      c_err_q     <= 1'b0;
      c_rdata_q   <= 32'h0;
      l_ack_q     <= 1'b0;
      l_err_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c || grant_l) begin
            own_q       <= grant_l;
            rr_q        <= grant_c;
            we_q        <= g_we;
            uns_q       <= g_uns;
            err_q       <= g_err;
            size_q      <= g_size;
            alo_q       <= g_addr[1:0];
            mem_addr_q  <= {g_addr[31:2], 2'b00};
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_addr_q  <= 32'h0;
          mem_we_q    <= 4'b0000;
          mem_wdata_q <= 32'h0;
          if (!own_q) begin
            c_rvalid_q <= 1'b1;
            c_err_q    <= err_q;
            c_rdata_q  <= (we_q || err_q) ? 32'h0 : ld_data_d;
          end else begin
            l_ack_q <= 1'b1;
            l_err_q <= err_q;
          end
          state_q <= RESP;
        end
        RESP: begin
          c_rvalid_q <= 1'b0;
          l_ack_q    <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a byte-array reference model
module tb_dmem_ctrl;
  localparam int MW = 151;

  logic clk;
  logic rst_n;
  dmem_ctrl_if bus ();

  dmem_ctrl #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks;
  int errors;
  int cyc;
  int acc_c;
  int resp_c;
  bit model_on;
  bit rr_m;
  bit env_clear;

  logic [31:0] lanes   [0:1023];
  logic [7:0]  ref_mem [0:MW*4-1];

  logic        e_own;
  logic        e_err;
  logic [3:0]  e_we;
  logic [31:0] e_addr;
  logic [31:0] e_wd;
  logic [31:0] e_rd;

  logic [3:0]  s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic        s_rv;
  logic [31:0] s_rd;
  logic        s_er;
  logic [8:0]  cr_bits;
  logic [8:0]  lr_bits;
  bit          ok;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Four byte-lane memories: combinational read, byte-enabled write.
  assign bus.mem_rdata = lanes[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (env_clear) begin
      for (int j = 0; j < 1024; j++) lanes[j] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) lanes[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, one access at a time.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int nb;
    int base;
    logic [31:0] val;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_err = (size == 2'd3) || ((addr % 32'(nb)) != 32'h0) || ((addr >> 2) >= 32'(MW));
    e_addr = addr & 32'hFFFF_FFFC;
    e_we = 4'h0;
    e_wd = 32'h0;
    e_rd = 32'h0;
    base = int'(addr[11:0]);
    if (!e_err && we) begin
      for (int k = 0; k < nb; k++) begin
        e_we[int'(addr[1:0]) + k] = 1'b1;
        ref_mem[base + k] = wdata[8*k +: 8];
      end
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    if (!e_err && !we) begin
      val = 32'h0;
      for (int k = 0; k < nb; k++) val[8*k +: 8] = ref_mem[base + k];
      if (nb < 4 && !uns && val[8*nb-1])
        for (int b = 8*nb; b < 32; b++) val[b] = 1'b1;
      e_rd = val;
    end
  endtask

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    bit idle;
    bit exp_cr;
    bit exp_lr;
    cyc++;
    if (!rst_n) begin
      acc_c  = -10;
      resp_c = -10;
      rr_m   = 1'b0;
    end else if (model_on) begin
      idle   = (cyc > resp_c);
      exp_cr = idle && bus.c_req && (!bus.l_req || !rr_m);
      exp_lr = idle && bus.l_req && !exp_cr;
      chk("c_ready", 32'(bus.c_ready), 32'(exp_cr));
      chk("l_ready", 32'(bus.l_ready), 32'(exp_lr));
      if (cyc == acc_c) begin
        chk("acc_mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("acc_mem_addr", bus.mem_addr, e_addr);
        if (e_we != 4'h0) chk("acc_mem_wdata", bus.mem_wdata, e_wd);
      end else begin
        chk("idle_mem_we", 32'(bus.mem_we), 32'h0);
        chk("idle_mem_addr", bus.mem_addr, 32'h0);
        chk("idle_mem_wdata", bus.mem_wdata, 32'h0);
      end
      if (cyc == resp_c) begin
        if (!e_own) begin
          chk("c_rvalid", 32'(bus.c_rvalid), 32'h1);
          chk("c_err", 32'(bus.c_err), 32'(e_err));
          chk("c_rdata", bus.c_rdata, e_rd);
          chk("l_ack_quiet", 32'(bus.l_ack), 32'h0);
        end else begin
          chk("l_ack", 32'(bus.l_ack), 32'h1);
          chk("l_err", 32'(bus.l_err), 32'(e_err));
          chk("c_rvalid_quiet", 32'(bus.c_rvalid), 32'h0);
        end
      end else begin
        chk("c_rvalid_quiet", 32'(bus.c_rvalid), 32'h0);
        chk("l_ack_quiet", 32'(bus.l_ack), 32'h0);
      end
      if (exp_cr) predict(bus.c_we, bus.c_size, bus.c_unsigned, bus.c_addr, bus.c_wdata);
      else if (exp_lr) predict(1'b1, 2'b10, 1'b0, bus.l_addr, bus.l_wdata);
      if (exp_cr || exp_lr) begin
        e_own  = exp_lr;
        acc_c  = cyc + 1;
        resp_c = cyc + 2;
        rr_m   = exp_cr;
      end
    end
  end

  task automatic core_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.c_req = 1'b1; bus.c_we = we; bus.c_size = size;
    bus.c_unsigned = uns; bus.c_addr = addr; bus.c_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.c_ready;
    end
    chk("core_accept", 32'(got), 32'h1);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    @(negedge clk);
    s_we = bus.mem_we; s_addr = bus.mem_addr; s_wd = bus.mem_wdata;
    @(negedge clk);
    s_rv = bus.c_rvalid; s_rd = bus.c_rdata; s_er = bus.c_err;
  endtask

  task automatic loader_txn(input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.l_req = 1'b1; bus.l_addr = addr; bus.l_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.l_ready;
    end
    chk("loader_accept", 32'(got), 32'h1);
    @(posedge clk); #1;
    bus.l_req = 1'b0;
    @(negedge clk);
    s_we = bus.mem_we; s_addr = bus.mem_addr; s_wd = bus.mem_wdata;
    @(negedge clk);
    s_rv = bus.l_ack; s_rd = 32'h0; s_er = bus.l_err;
  endtask

  task automatic expect_resp(input string nm, input logic [3:0] we, input logic [31:0] rd, input logic er);
    chk({nm, "_mem_we"}, 32'(s_we), 32'(we));
    chk({nm, "_valid"}, 32'(s_rv), 32'h1);
    chk({nm, "_rdata"}, s_rd, rd);
    chk({nm, "_err"}, 32'(s_er), 32'(er));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    acc_c = -10; resp_c = -10; rr_m = 1'b0;
    model_on = 1'b1; env_clear = 1'b1;
    for (int i = 0; i < MW*4; i++) ref_mem[i] = 8'h0;
    rst_n = 1'b0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_size = 2'b00; bus.c_unsigned = 1'b0;
    bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
    bus.l_req = 1'b0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_c_ready", 32'(bus.c_ready), 32'h0);
    chk("rst_l_ready", 32'(bus.l_ready), 32'h0);
    chk("rst_c_rvalid", 32'(bus.c_rvalid), 32'h0);
    chk("rst_c_rdata", bus.c_rdata, 32'h0);
    chk("rst_c_err", 32'(bus.c_err), 32'h0);
    chk("rst_l_ack", 32'(bus.l_ack), 32'h0);
    chk("rst_l_err", 32'(bus.l_err), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

    // Both requesters held from reset: core, loader, core, 3 cycles apart.
    @(posedge clk); #1;
    env_clear = 1'b0; rst_n = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_addr = 32'h0;
    bus.l_req = 1'b1; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cr_bits[i] = bus.c_ready;
      lr_bits[i] = bus.l_ready;
    end
    chk("arb_core_grants", 32'(cr_bits), 32'h041);
    chk("arb_loader_grants", 32'(lr_bits), 32'h008);
    @(posedge clk); #1;
    bus.c_req = 1'b0; bus.l_req = 1'b0;

    core_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    expect_resp("sw", 4'hF, 32'h0, 1'b0);
    chk("sw_mem_addr", s_addr, 32'h10);
    chk("sw_mem_wdata", s_wd, 32'hDEADBEEF);
    core_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    expect_resp("lw", 4'h0, 32'hDEADBEEF, 1'b0);

    core_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h80);
    expect_resp("sb", 4'h8, 32'h0, 1'b0);
    chk("sb_mem_wdata", s_wd, 32'h80808080);
    core_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    expect_resp("lb", 4'h0, 32'hFFFFFF80, 1'b0);
    core_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    expect_resp("lbu", 4'h0, 32'h00000080, 1'b0);
    core_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    expect_resp("lh", 4'h0, 32'hFFFF80AD, 1'b0);

    core_txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    expect_resp("lh_mis", 4'h0, 32'h0, 1'b1);
    core_txn(1'b1, 2'b10, 1'b0, 32'h22, 32'h11223344);
    expect_resp("sw_mis", 4'h0, 32'h0, 1'b1);
    core_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    expect_resp("size11", 4'h0, 32'h0, 1'b1);

    core_txn(1'b0, 2'b10, 1'b0, 32'h25C, 32'h0);
    expect_resp("lw_oor", 4'h0, 32'h0, 1'b1);
    loader_txn(32'h258, 32'hCAFEF00D);
    expect_resp("ld_last", 4'hF, 32'h0, 1'b0);
    chk("ld_last_mem_addr", s_addr, 32'h258);
    core_txn(1'b0, 2'b10, 1'b0, 32'h258, 32'h0);
    expect_resp("lw_last", 4'h0, 32'hCAFEF00D, 1'b0);

    // Reset in the middle of a store's ACCESS cycle.
    model_on = 1'b0;
    @(posedge clk); #1;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_size = 2'b10; bus.c_unsigned = 1'b0;
    bus.c_addr = 32'h40; bus.c_wdata = 32'h12345678;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.c_ready;
    end
    chk("rst_store_accept", 32'(ok), 32'h1);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    @(negedge clk);
    chk("rst_pre_mem_we", 32'(bus.mem_we), 32'hF);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_mem_we", 32'(bus.mem_we), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rvalid", 32'(bus.c_rvalid), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; model_on = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_addr = 32'h40;
    bus.l_req = 1'b1; bus.l_addr = 32'h80; bus.l_wdata = 32'h5A5A0001;
    @(negedge clk);
    chk("rst_rr_core", 32'(bus.c_ready), 32'h1);
    chk("rst_rr_loader", 32'(bus.l_ready), 32'h0);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_load_rvalid", 32'(bus.c_rvalid), 32'h1);
    chk("rst_load_rdata", bus.c_rdata, 32'h0);
    @(negedge clk);
    chk("rst_loader_ready", 32'(bus.l_ready), 32'h1);
    @(posedge clk); #1;
    bus.l_req = 1'b0;

    // Randomized traffic from both requesters.
    fork
      begin : core_drv
        int r;
        int wi;
        logic [1:0] sz;
        logic [1:0] lo;
        bit got;
        for (int n = 0; n < 90; n++) begin
          r  = int'($urandom_range(0, 9));
          sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
          wi = int'($urandom_range(0, 160));
          if ($urandom_range(0, 4) == 0) lo = 2'($urandom_range(0, 3));
          else if (sz == 2'd0) lo = 2'($urandom_range(0, 3));
          else if (sz == 2'd1) lo = {1'($urandom_range(0, 1)), 1'b0};
          else lo = 2'b00;
          @(posedge clk); #1;
          bus.c_req = 1'b1; bus.c_we = 1'($urandom_range(0, 1)); bus.c_size = sz;
          bus.c_unsigned = 1'($urandom_range(0, 1));
          bus.c_addr = 32'(wi * 4) + 32'(lo); bus.c_wdata = $urandom;
          got = 1'b0;
          for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.c_ready;
          end
          chk("rnd_core_accept", 32'(got), 32'h1);
          @(posedge clk); #1;
          bus.c_req = 1'b0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin : loader_drv
        int wi;
        logic [1:0] lo;
        bit got;
        for (int n = 0; n < 70; n++) begin
          wi = int'($urandom_range(0, 155));
          lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          @(posedge clk); #1;
          bus.l_req = 1'b1; bus.l_addr = 32'(wi * 4) + 32'(lo); bus.l_wdata = $urandom;
          got = 1'b0;
          for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.l_ready;
          end
          chk("rnd_loader_accept", 32'(got), 32'h1);
          @(posedge clk); #1;
          bus.l_req = 1'b0;
          repeat ($urandom_range(0, 5)) @(posedge clk);
        end
      end
    join

    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
